// File: rtl/tmr_recovery_sequencer.sv
// Single-fault recovery sequencer for triple-redundant cores: rollback history, register restore injection, PC reload.
// Optional TMR_RECOVERY_STATS_EN enables the saturating recovery_count; otherwise it is tied to zero.
module tmr_recovery_sequencer #(
  parameter int unsigned HIST_DEPTH   = 2,
  parameter logic [11:0] RESTORE_BASE = 12'h100,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic [2:0]  voter_state,
  input  logic [31:0] pc_voted,
  input  logic [31:0] instr_voted,
  input  logic        instr_valid,
  input  logic        inj_ready,
  output logic [31:0] inj_instr,
  output logic        inj_valid,
  output logic [31:0] pc_restart,
  output logic        pc_restart_load,
  output logic        core_hold,
  output logic        recovery_active,
  output logic [1:0]  fault_core,
  output logic        fatal_err,
  output logic [7:0]  recovery_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_INJ_RD, S_INJ_RS1, S_INJ_RS2, S_RESTART, S_FATAL
  } state_t;

  localparam int PW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam int OW = $clog2(HIST_DEPTH + 1);
  localparam logic [PW-1:0] WP_LAST   = PW'(HIST_DEPTH - 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(HIST_DEPTH);
  localparam logic [PW:0]   DEPTH_EXT = (PW+1)'(HIST_DEPTH);
  localparam logic [2:0]    RETRY_MAX = 3'(MAX_RETRY);

  state_t state, state_nxt;

  // History keeps only the PC and the three register fields needed for restore.
  logic [31:0]   hist_pc   [HIST_DEPTH];
  logic [14:0]   hist_regs [HIST_DEPTH];
  logic [PW-1:0] wp;
  logic [OW-1:0] occ;
  logic [PW:0]   oldest_sum;
  logic [PW-1:0] oldest;
  logic [2:0]    retry;

  logic [31:0] e_pc;
  logic [14:0] e_regs;
  logic        e_valid;
  logic [1:0]  fault_idx;

  logic [1:0]  agree_cnt;
  logic        push;
  logic        in_inj;
  logic [4:0]  cur_reg;
  logic [11:0] restore_imm;
  logic        inj_want;

  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_voted[31:25], instr_voted[14:12], instr_voted[6:0]};

  assign agree_cnt = 2'(voter_state[0]) + 2'(voter_state[1]) + 2'(voter_state[2]);
  assign push      = (state == S_IDLE) && instr_valid && (voter_state == 3'b111);

  always_comb begin
    oldest_sum = (PW+1)'(wp) + DEPTH_EXT - (PW+1)'(occ);
    if (oldest_sum >= DEPTH_EXT) begin
      oldest_sum = oldest_sum - DEPTH_EXT;
    end
    oldest = oldest_sum[PW-1:0];
  end

  always_comb begin
    case (state)
      S_INJ_RS1: cur_reg = e_regs[9:5];
      S_INJ_RS2: cur_reg = e_regs[14:10];
      default:   cur_reg = e_regs[4:0];
    endcase
  end

  // inj_valid/inj_ready: while inj_valid is high inj_instr is held constant; the
  // transfer happens on the rising edge where both are high, and only then does the FSM advance.
  assign in_inj      = (state == S_INJ_RD) || (state == S_INJ_RS1) || (state == S_INJ_RS2);
  assign inj_want    = in_inj && e_valid && (cur_reg != 5'd0);
  assign restore_imm = RESTORE_BASE + {5'd0, cur_reg, 2'b00};

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (agree_cnt < 2'd2)       state_nxt = S_FATAL;
        else if (agree_cnt == 2'd2) state_nxt = S_HOLD;
      end
      S_HOLD:    state_nxt = (retry == RETRY_MAX) ? S_FATAL : S_INJ_RD;
      S_INJ_RD:  if (!inj_want || inj_ready) state_nxt = S_INJ_RS1;
      S_INJ_RS1: if (!inj_want || inj_ready) state_nxt = S_INJ_RS2;
      S_INJ_RS2: if (!inj_want || inj_ready) state_nxt = S_RESTART;
      S_RESTART: state_nxt = S_IDLE;
      S_FATAL:   state_nxt = S_FATAL;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      hist_pc[wp]   <= pc_voted;
      hist_regs[wp] <= {instr_voted[24:20], instr_voted[19:15], instr_voted[11:7]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      wp        <= '0;
      occ       <= '0;
      retry     <= '0;
      e_pc      <= '0;
      e_regs    <= '0;
      e_valid   <= 1'b0;
      fault_idx <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (push) begin
            wp    <= (wp == WP_LAST) ? '0 : wp + PW'(1);
            retry <= '0;
            if (occ != OCC_FULL) occ <= occ + OW'(1);
          end else if (agree_cnt == 2'd2) begin
            fault_idx <= !voter_state[0] ? 2'd0 : (!voter_state[1] ? 2'd1 : 2'd2);
          end
        end
        S_HOLD: begin
          e_valid <= (occ != '0);
          e_pc    <= (occ != '0) ? hist_pc[oldest] : 32'h0;
          e_regs  <= hist_regs[oldest];
        end
        S_RESTART: begin
          occ   <= '0;
          retry <= retry + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef TMR_RECOVERY_STATS_EN
  logic [7:0] rec_cnt;
  always_ff @(posedge clk) begin
    if (rst_in) begin
      rec_cnt <= 8'd0;
    end else if (state == S_RESTART && rec_cnt != 8'hff) begin
      rec_cnt <= rec_cnt + 8'd1;
    end
  end
  assign recovery_count = rec_cnt;
`else
  assign recovery_count = 8'd0;
`endif

  assign inj_valid       = inj_want;
  assign inj_instr       = inj_want ? {restore_imm, 5'd0, 3'b010, cur_reg, 7'b0000011} : 32'h0;
  assign pc_restart_load = (state == S_RESTART);
  assign pc_restart      = (state == S_RESTART) ? e_pc : 32'h0;
  assign core_hold       = (state != S_IDLE);
  assign recovery_active = (state != S_IDLE);
  assign fatal_err       = (state == S_FATAL);
  assign fault_core      = fault_idx;
  assign state_dbg       = state;

endmodule

// File: tb/tb_tmr_recovery_sequencer.sv
// Self-checking bench for tmr_recovery_sequencer: scenario tasks with inline checks plus a
// scoreboard of expected injections and restart PCs.
module tb_tmr_recovery_sequencer;

  localparam int HIST_DEPTH = 2;
  localparam int MAX_RETRY  = 3;
`ifdef TMR_RECOVERY_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_in;
  logic [2:0]  voter_state;
  logic [31:0] pc_voted;
  logic [31:0] instr_voted;
  logic        instr_valid;
  logic        inj_ready;
  logic [31:0] inj_instr;
  logic        inj_valid;
  logic [31:0] pc_restart;
  logic        pc_restart_load;
  logic        core_hold;
  logic        recovery_active;
  logic [1:0]  fault_core;
  logic        fatal_err;
  logic [7:0]  recovery_count;
  logic [2:0]  state_dbg;

  tmr_recovery_sequencer #(
    .HIST_DEPTH(HIST_DEPTH), .RESTORE_BASE(12'h100), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_in(rst_in), .voter_state(voter_state), .pc_voted(pc_voted),
    .instr_voted(instr_voted), .instr_valid(instr_valid), .inj_ready(inj_ready),
    .inj_instr(inj_instr), .inj_valid(inj_valid), .pc_restart(pc_restart),
    .pc_restart_load(pc_restart_load), .core_hold(core_hold),
    .recovery_active(recovery_active), .fault_core(fault_core), .fatal_err(fatal_err),
    .recovery_count(recovery_count), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] m_pc[$];
  logic [31:0] m_instr[$];
  int          m_retry = 0;

  function automatic logic [31:0] lw_enc(input logic [4:0] r);
    logic [11:0] imm;
    imm = 12'h100 + {5'd0, r, 2'b00};
    return {imm, 5'd0, 3'b010, r, 7'b0000011};
  endfunction

  // Scoreboard: every accepted injection and every restart pulse consumes one expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (inj_valid && inj_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_inj_unexpected got=%h", inj_instr);
      end else begin
        e = exp_q.pop_front();
        if (inj_instr !== e) begin
          errors++;
          $display("FAIL sb_inj got=%h exp=%h", inj_instr, e);
        end
      end
    end
    if (pc_restart_load) begin
      checks++;
      if (exp_pc_q.size() == 0) begin
        errors++;
        $display("FAIL sb_load_unexpected got_pc=%h", pc_restart);
      end else begin
        e = exp_pc_q.pop_front();
        if (pc_restart !== e) begin
          errors++;
          $display("FAIL sb_pc got=%h exp=%h", pc_restart, e);
        end
      end
    end
  end

  // ---------------- model ----------------
  task automatic model_reset();
    exp_q.delete();
    exp_pc_q.delete();
    m_pc.delete();
    m_instr.delete();
    m_retry = 0;
  endtask

  task automatic model_push(input logic [31:0] pc, input logic [31:0] instr);
    m_pc.push_back(pc);
    m_instr.push_back(instr);
    if (m_pc.size() > HIST_DEPTH) begin
      void'(m_pc.pop_front());
      void'(m_instr.pop_front());
    end
    m_retry = 0;
  endtask

  task automatic model_fault(output bit fatal);
    logic [31:0] ins;
    fatal = (m_retry == MAX_RETRY);
    if (!fatal) begin
      if (m_pc.size() == 0) begin
        exp_pc_q.push_back(32'h0);
      end else begin
        ins = m_instr[0];
        if (ins[11:7]  != 5'd0) exp_q.push_back(lw_enc(ins[11:7]));
        if (ins[19:15] != 5'd0) exp_q.push_back(lw_enc(ins[19:15]));
        if (ins[24:20] != 5'd0) exp_q.push_back(lw_enc(ins[24:20]));
        exp_pc_q.push_back(m_pc[0]);
      end
      m_pc.delete();
      m_instr.delete();
      m_retry++;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    voter_state = 3'b111;
    instr_valid = 1'b0;
    inj_ready = 1'b1;
    pc_voted = 32'h0;
    instr_voted = 32'h0;
    step();
    step();
    rst_in = 1'b0;
    model_reset();
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] instr);
    voter_state = 3'b111;
    instr_valid = 1'b1;
    pc_voted = pc;
    instr_voted = instr;
    model_push(pc, instr);
    step();
    instr_valid = 1'b0;
  endtask

  // Leaves the bench in cycle N+1 relative to the fault cycle N.
  task automatic inject_fault(input logic [2:0] v, input logic with_commit,
                              input logic [31:0] pc, input logic [31:0] instr, output bit fatal);
    voter_state = v;
    instr_valid = with_commit;
    pc_voted = pc;
    instr_voted = instr;
    fatal = 1'b0;
    if (v inside {3'b110, 3'b101, 3'b011}) model_fault(fatal);
    step();
    voter_state = 3'b111;
    instr_valid = 1'b0;
  endtask

  task automatic wait_release(input int budget);
    int n;
    n = 0;
    while (core_hold === 1'b1 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (core_hold !== 1'b0) begin
      errors++;
      $display("FAIL release_timeout core_hold=%b after %0d cycles", core_hold, n);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    voter_state = 3'b010;
    instr_valid = 1'b1;
    do_reset();
    checks++;
    if ({inj_instr, inj_valid, pc_restart, pc_restart_load, core_hold, recovery_active,
         fault_core, fatal_err, recovery_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs inj=%h v=%b pc=%h ld=%b hold=%b act=%b fc=%0d fe=%b cnt=%0d exp all 0",
               inj_instr, inj_valid, pc_restart, pc_restart_load, core_hold, recovery_active,
               fault_core, fatal_err, recovery_count);
    end
  endtask

  task automatic test_basic_recovery();
    bit f;
    do_reset();
    commit(32'h0, 32'h00000013);
    commit(32'h4, 32'h002081b3);
    commit(32'h8, 32'h00000013);
    inject_fault(3'b110, 1'b0, 32'h0, 32'h0, f);
    checks++;
    if (core_hold !== 1'b1 || fault_core !== 2'd0 || inj_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_hold hold=%b fc=%0d v=%b exp 1/0/0", core_hold, fault_core, inj_valid);
    end
    step();
    checks++;
    if (inj_valid !== 1'b1 || inj_instr !== 32'h10C02183) begin
      errors++;
      $display("FAIL t1_inj_rd v=%b got=%h exp=10c02183", inj_valid, inj_instr);
    end
    step();
    checks++;
    if (inj_valid !== 1'b1 || inj_instr !== 32'h10402083) begin
      errors++;
      $display("FAIL t1_inj_rs1 v=%b got=%h exp=10402083", inj_valid, inj_instr);
    end
    step();
    checks++;
    if (inj_valid !== 1'b1 || inj_instr !== 32'h10802103) begin
      errors++;
      $display("FAIL t1_inj_rs2 v=%b got=%h exp=10802103", inj_valid, inj_instr);
    end
    step();
    checks++;
    if (pc_restart_load !== 1'b1 || pc_restart !== 32'h4 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL t1_load ld=%b pc=%h hold=%b exp 1/4/1", pc_restart_load, pc_restart, core_hold);
    end
    step();
    checks++;
    if (core_hold !== 1'b0 || pc_restart_load !== 1'b0 || recovery_active !== 1'b0) begin
      errors++;
      $display("FAIL t1_release hold=%b ld=%b act=%b exp 0", core_hold, pc_restart_load, recovery_active);
    end
    checks++;
    if (recovery_count !== (STATS ? 8'd1 : 8'd0)) begin
      errors++;
      $display("FAIL t1_count got=%0d exp=%0d", recovery_count, STATS ? 1 : 0);
    end
  endtask

  task automatic test_skip_rd();
    bit f;
    commit(32'h20, 32'h00208033);
    commit(32'h24, 32'h00000013);
    inject_fault(3'b101, 1'b0, 32'h0, 32'h0, f);
    checks++;
    if (fault_core !== 2'd1) begin
      errors++;
      $display("FAIL t2_fault_core got=%0d exp=1", fault_core);
    end
    step();
    checks++;
    if (inj_valid !== 1'b0 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL t2_rd_skip v=%b hold=%b exp 0/1", inj_valid, core_hold);
    end
    step();
    checks++;
    if (inj_valid !== 1'b1 || inj_instr !== 32'h10402083) begin
      errors++;
      $display("FAIL t2_inj_x1 v=%b got=%h exp=10402083", inj_valid, inj_instr);
    end
    step();
    checks++;
    if (inj_valid !== 1'b1 || inj_instr !== 32'h10802103) begin
      errors++;
      $display("FAIL t2_inj_x2 v=%b got=%h exp=10802103", inj_valid, inj_instr);
    end
    step();
    checks++;
    if (pc_restart_load !== 1'b1 || pc_restart !== 32'h20) begin
      errors++;
      $display("FAIL t2_load ld=%b pc=%h exp 1/20", pc_restart_load, pc_restart);
    end
    wait_release(10);
  endtask

  task automatic test_inj_stall();
    bit f;
    commit(32'h40, 32'h002081b3);
    inject_fault(3'b011, 1'b0, 32'h0, 32'h0, f);
    checks++;
    if (fault_core !== 2'd2) begin
      errors++;
      $display("FAIL t3_fault_core got=%0d exp=2", fault_core);
    end
    step();
    step();
    inj_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (inj_valid !== 1'b1 || inj_instr !== 32'h10402083) begin
        errors++;
        $display("FAIL t3_stall_%0d v=%b got=%h exp=10402083", i, inj_valid, inj_instr);
      end
      step();
    end
    inj_ready = 1'b1;
    checks++;
    if (inj_valid !== 1'b1 || inj_instr !== 32'h10402083) begin
      errors++;
      $display("FAIL t3_ready_cycle v=%b got=%h exp=10402083", inj_valid, inj_instr);
    end
    step();
    checks++;
    if (inj_instr !== 32'h10802103) begin
      errors++;
      $display("FAIL t3_advance got=%h exp=10802103", inj_instr);
    end
    step();
    checks++;
    if (pc_restart_load !== 1'b1 || pc_restart !== 32'h40) begin
      errors++;
      $display("FAIL t3_load ld=%b pc=%h exp 1/40", pc_restart_load, pc_restart);
    end
    wait_release(10);
  endtask

  task automatic test_fatal_voter();
    bit f;
    do_reset();
    inject_fault(3'b100, 1'b0, 32'h0, 32'h0, f);
    checks++;
    if (fatal_err !== 1'b1 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL t4_fatal fe=%b hold=%b exp 1/1", fatal_err, core_hold);
    end
    voter_state = 3'b111;
    instr_valid = 1'b1;
    pc_voted = 32'h300;
    for (int i = 0; i < 5; i++) step();
    instr_valid = 1'b0;
    checks++;
    if (fatal_err !== 1'b1 || core_hold !== 1'b1) begin
      errors++;
      $display("FAIL t4_sticky fe=%b hold=%b exp 1/1", fatal_err, core_hold);
    end
    do_reset();
    checks++;
    if (fatal_err !== 1'b0 || core_hold !== 1'b0) begin
      errors++;
      $display("FAIL t4_reset_exit fe=%b hold=%b exp 0/0", fatal_err, core_hold);
    end
  endtask

  task automatic test_retry_limit();
    bit f;
    do_reset();
    for (int k = 0; k < MAX_RETRY; k++) begin
      inject_fault(3'b110, 1'b0, 32'h0, 32'h0, f);
      wait_release(20);
    end
    inject_fault(3'b110, 1'b0, 32'h0, 32'h0, f);
    checks++;
    if (core_hold !== 1'b1 || fatal_err !== 1'b0) begin
      errors++;
      $display("FAIL t4_retry_hold hold=%b fe=%b exp 1/0", core_hold, fatal_err);
    end
    step();
    checks++;
    if (fatal_err !== 1'b1 || f !== 1'b1) begin
      errors++;
      $display("FAIL t4_retry_fatal fe=%b exp 1", fatal_err);
    end
    step();
    step();
    do_reset();
  endtask

  task automatic test_reset_mid_recovery();
    bit f;
    do_reset();
    commit(32'h80, 32'h002081b3);
    commit(32'h84, 32'h00000013);
    inject_fault(3'b110, 1'b0, 32'h0, 32'h0, f);
    step();
    step();
    checks++;
    if (inj_valid !== 1'b1 || inj_instr !== 32'h10402083) begin
      errors++;
      $display("FAIL t5_in_rs1 v=%b got=%h exp=10402083", inj_valid, inj_instr);
    end
    rst_in = 1'b1;
    step();
    checks++;
    if ({inj_instr, inj_valid, pc_restart, pc_restart_load, core_hold, recovery_active,
         fault_core, fatal_err, recovery_count} !== '0) begin
      errors++;
      $display("FAIL t5_reset_outputs v=%b hold=%b ld=%b fc=%0d cnt=%0d exp all 0",
               inj_valid, core_hold, pc_restart_load, fault_core, recovery_count);
    end
    rst_in = 1'b0;
    model_reset();
    inject_fault(3'b110, 1'b0, 32'h0, 32'h0, f);
    step();
    checks++;
    if (inj_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_occ0_noinj v=%b exp 0", inj_valid);
    end
    step();
    step();
    step();
    checks++;
    if (pc_restart_load !== 1'b1 || pc_restart !== 32'h0) begin
      errors++;
      $display("FAIL t5_occ0_load ld=%b pc=%h exp 1/0", pc_restart_load, pc_restart);
    end
    wait_release(10);
  endtask

  task automatic test_fault_with_commit();
    bit f;
    do_reset();
    inject_fault(3'b110, 1'b1, 32'hB0, 32'h002081b3, f);
    step();
    checks++;
    if (inj_valid !== 1'b0) begin
      errors++;
      $display("FAIL t5_nopush_inj v=%b exp 0", inj_valid);
    end
    step();
    step();
    step();
    checks++;
    if (pc_restart_load !== 1'b1 || pc_restart !== 32'h0) begin
      errors++;
      $display("FAIL t5_nopush_pc ld=%b pc=%h exp 1/0", pc_restart_load, pc_restart);
    end
    wait_release(10);
  endtask

  task automatic test_count_saturation();
    bit f;
    logic [4:0] r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = 5'($urandom_range(0, 31));
      commit(32'h1000 + 32'(4 * i), {12'h000, r, 3'b000, 5'd0, 7'b0010011});
      inject_fault(3'b110, 1'b0, 32'h0, 32'h0, f);
      wait_release(20);
    end
    checks++;
    if (recovery_count !== (STATS ? 8'd255 : 8'd0)) begin
      errors++;
      $display("FAIL t6_count got=%0d exp=%0d", recovery_count, STATS ? 255 : 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    voter_state = 3'b111;
    instr_valid = 1'b0;
    inj_ready = 1'b1;
    pc_voted = 32'h0;
    instr_voted = 32'h0;
    test_reset();
    test_basic_recovery();
    test_skip_rd();
    test_inj_stall();
    test_fatal_voter();
    test_retry_limit();
    test_reset_mid_recovery();
    test_fault_with_commit();
    test_count_saturation();
    step();
    checks++;
    if (exp_q.size() != 0 || exp_pc_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain inj_left=%0d pc_left=%0d exp 0/0", exp_q.size(), exp_pc_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
